// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
// Holds the FSM encoding and the round-robin pick used by rr_pick.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ABORT
  } arb_state_t;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  // Lowest offset above the pointer wins, with wrap-around over n inputs.
  function automatic logic [MAX_REQ-1:0] rr_onehot(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   last,
    input int                 n
  );
    logic [MAX_REQ-1:0] g;
    int idx;
    g = '0;
    for (int i = n; i >= 1; i--) begin
      idx = (int'(last) + i) % n;
      if (req[idx]) begin
        g = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(
    input logic [MAX_REQ-1:0] oh
  );
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: one-hot winner among req,
// scanning upward from the slot after last.
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt
);

  logic [MAX_REQ-1:0] req_w;
  logic [MAX_REQ-1:0] gnt_w;

  always_comb begin
    req_w = '0;
    req_w[N-1:0] = req;
  end

  assign gnt_w = rr_onehot(req_w, last, N);
  assign gnt   = gnt_w[N-1:0];

  generate
    if (N < MAX_REQ) begin : g_hi
      logic unused_hi;
      assign unused_hi = |gnt_w[MAX_REQ-1:N];
    end
  endgenerate

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one master port shared by NUM_REQ
// requesters, with a no-ack watchdog that aborts stuck bus cycles.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_cyc_i,
  input  logic [NUM_REQ-1:0]       req_stb_i,
  input  logic [NUM_REQ-1:0]       req_we_i,
  input  logic [NUM_REQ*ADR_W-1:0] req_adr_i,
  input  logic [NUM_REQ*DAT_W-1:0] req_dat_i,
  output logic [NUM_REQ-1:0]       req_ack_o,
  output logic [NUM_REQ-1:0]       req_err_o,
  output logic [DAT_W-1:0]         req_dat_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     m_cyc_o,
  output logic                     m_stb_o,
  output logic                     m_we_o,
  output logic [ADR_W-1:0]         m_adr_o,
  output logic [DAT_W-1:0]         m_dat_o,
  input  logic                     m_ack_i,
  input  logic [DAT_W-1:0]         m_dat_i,
  output logic                     timeout_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t         state;
  arb_state_t         state_nx;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] pick;
  logic [MAX_REQ-1:0] pick_w;
  logic [IDX_W-1:0]   last;
  logic               err_pend;
  logic               expire;
  logic               g_cyc;
  logic               g_stb;
  logic               g_we;

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req  (req_cyc_i),
    .last (last),
    .gnt  (pick)
  );

  always_comb begin
    pick_w = '0;
    pick_w[NUM_REQ-1:0] = pick;
  end

  assign g_cyc = |(grant & req_cyc_i);
  assign g_stb = |(grant & req_stb_i);
  assign g_we  = |(grant & req_we_i);

  generate
    if (TIMEOUT > 0) begin : g_wd
      logic [CW-1:0] cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (state != BUSY || m_ack_i) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      assign expire = (cnt == CW'(TIMEOUT - 1));
    end else begin : g_nowd
      assign expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      last     <= IDX_W'(NUM_REQ - 1);
      err_pend <= 1'b0;
    end else begin
      state    <= state_nx;
      err_pend <= (state == BUSY) && (state_nx == ABORT);
      if (state == IDLE && state_nx == BUSY) begin
        grant <= pick;
        last  <= to_idx(pick_w);
      end else if (state_nx == IDLE) begin
        grant <= '0;
      end
    end
  end

  // Ack beats an expiry landing on the same cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (|req_cyc_i) state_nx = BUSY;
      BUSY: begin
        if (!g_cyc)                state_nx = IDLE;
        else if (!m_ack_i && expire) state_nx = ABORT;
      end
      ABORT:   if (!g_cyc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    m_cyc_o   = 1'b0;
    m_stb_o   = 1'b0;
    m_we_o    = 1'b0;
    req_ack_o = '0;
    req_err_o = '0;
    timeout_o = 1'b0;
    m_adr_o   = '0;
    m_dat_o   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        m_adr_o = req_adr_i[k*ADR_W +: ADR_W];
        m_dat_o = req_dat_i[k*DAT_W +: DAT_W];
      end
    end
    unique case (state)
      BUSY: begin
        m_cyc_o   = g_cyc;
        m_stb_o   = g_stb;
        m_we_o    = g_we;
        req_ack_o = grant & {NUM_REQ{m_ack_i}};
      end
      ABORT: begin
        req_err_o = grant & {NUM_REQ{err_pend}};
        timeout_o = err_pend;
      end
      default: ;
    endcase
  end

  assign req_dat_o = m_dat_i;
  assign grant_o   = grant;

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Shares one Wishbone master port between NUM_REQ requesters, e.g. the OK pipe bridge and a softcore data port, in front of the peripheral interconnect.
- Arbitration is round-robin and per bus cycle: a grant is held for as long as the winner keeps cyc high.
- A watchdog aborts bus cycles that receive no ack and returns an error to the requester, so an unmapped address cannot lock up the host bridge.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADR_W, 32, address width
DAT_W, 32, data width
TIMEOUT, 255, cycles without ack before abort; 0 disables the watchdog

Ports:
clk  in  1  system clock, also driven onto the downstream interface clock
rst_n  in  1  asynchronous, active-low reset
req_cyc_i  in  NUM_REQ  per-requester cyc
req_stb_i  in  NUM_REQ  per-requester stb
req_we_i  in  NUM_REQ  per-requester we
req_adr_i  in  NUM_REQ*ADR_W  packed addresses, requester k at [k*ADR_W +: ADR_W]
req_dat_i  in  NUM_REQ*DAT_W  packed write data
req_ack_o  out  NUM_REQ  ack, routed to the granted requester only
req_err_o  out  NUM_REQ  one-cycle timeout error, granted requester only
req_dat_o  out  DAT_W  read data, broadcast to all requesters (qualified by ack)
grant_o  out  NUM_REQ  one-hot current grant; all zero when idle
m_cyc_o  out  1  master cyc
m_stb_o  out  1  master stb
m_we_o  out  1  master we
m_adr_o  out  ADR_W  master address
m_dat_o  out  DAT_W  master write data
m_ack_i  in  1  slave ack
m_dat_i  in  DAT_W  slave read data
timeout_o  out  1  one-cycle pulse on every abort (status/debug)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: grant_o=0, all req_ack_o/req_err_o=0, m_cyc_o=m_stb_o=m_we_o=0, timeout_o=0, watchdog count=0, state=IDLE, priority pointer set so that requester 0 is highest priority.
- States: IDLE, BUSY, ABORT.
- IDLE:
  - If any req_cyc_i is high, pick the first high bit scanning from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - Register that one-hot grant, set last_grant to the winner, go to BUSY.
  - One cycle of arbitration latency: m_cyc_o rises on the cycle after the winner's req_cyc_i is first sampled.
- BUSY:
  - m_cyc_o, m_stb_o, m_we_o, m_adr_o and m_dat_o are a combinational mux of the granted requester's inputs. m_cyc_o and m_stb_o are gated by the grant.
  - req_ack_o[g] = m_ack_i. req_dat_o = m_dat_i, passed through without a register.
  - Granted requester drops req_cyc_i -> grant_o=0 and state to IDLE on the next edge. That idle cycle is mandatory: it is the re-arbitration cycle, and back-to-back requesters observe one dead cycle between bus cycles.
  - Watchdog: counts cycles in BUSY with m_ack_i low; resets to 0 on every ack. Reaching TIMEOUT -> ABORT.
  - m_ack_i and a watchdog expiry in the same cycle: the ack wins and no abort occurs.
- ABORT:
  - m_cyc_o=m_stb_o=0, forcing the downstream slave to release.
  - req_err_o[g]=1 and timeout_o=1 on the first ABORT cycle only.
  - req_ack_o stays 0.
  - Remain in ABORT until the granted req_cyc_i is low, then go to IDLE.
  - A late m_ack_i arriving in ABORT or IDLE is ignored and never forwarded.
- Non-granted requesters: ack=err=0 and inputs ignored; they wait with cyc held.
- Fairness: a requester that keeps cyc high across back-to-back transfers loses priority to any other pending requester at the next arbitration.
- Reset mid-transaction: all outputs drop asynchronously and the in-flight grant is discarded; requesters must reissue the request.
- TIMEOUT=0: ABORT is unreachable and the counter logic may be optimised away.
- Counter width: $clog2(TIMEOUT+1); the counter never wraps.

Decomposition:
- Package wb_arb_pkg: state enum {IDLE, BUSY, ABORT} and a function for the round-robin one-hot pick (mask, pointer).
- Sub-module rr_pick: combinational round-robin priority selector.
  - Inputs: req vector, last_grant index. Output: one-hot grant.
  - Instantiated once, so it can be unit-tested on its own.

Test Plan:
- Req0 alone: write adr 0x8000_0010, dat 0xDEAD_BEEF, slave acks 2 cycles after m_stb -> m_cyc_o high 1 cycle after req_cyc; req_ack_o=01 on the ack cycle; grant_o returns to 0 one cycle after req0 drops cyc.
- Req0 and req1 raise cyc on the same cycle out of reset -> req0 granted first; req1 granted on the second cycle after req0 drops cyc; a req0 re-request then waits for req1.
- NUM_REQ=3, all holding cyc continuously, 6 transfers -> grant order 0,1,2,0,1,2.
- TIMEOUT=8, slave never acks -> exactly 8 BUSY cycles, then req_err_o pulses for one cycle with timeout_o=1 and m_cyc_o=0; no ack forwarded; a later stale m_ack_i is ignored.
- m_ack_i asserted on the exact watchdog-expiry cycle -> normal ack, no err, no timeout_o.
- rst_n asserted while BUSY with req1 granted -> m_cyc_o and grant_o go to 0 immediately without waiting for clk; after release, req1 and req0 both pending -> req0 granted first.
